// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller and serializer.
// Accepts a parallel word with a valid strobe and drives the serial line with
// start bit, LSB-first data bits, an optional parity bit and a stop bit.
// One serial bit per clock: the block is clocked at the baud rate.
// The line is a register that is loaded with the value belonging to the state
// being entered, so the line and the state change on the same edge.
module uart_tx_frame_ctrl #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 CLK_TXC,
  input  logic                 RST_TXC,
  input  logic [DATA_SIZE-1:0] P_DATA_TXC,
  input  logic                 Data_valid_TXC,
  input  logic                 PAR_EN_TXC,
  input  logic                 par_bit_TXC,
  output logic                 TX_OUT_TXC,
  output logic                 busy_TXC
);

  // Bit counter is at least one bit wide, even for a single-bit word.
  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 tx_q,    tx_d;
  logic                 accept;

  // A new word is taken only when the line is idle or finishing a stop bit,
  // which is what allows back-to-back frames without an idle gap.
  assign accept = Data_valid_TXC && ((state_q == IDLE) || (state_q == STOP));

  // Next-state, shift register, counter and next line value.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;

    case (state_q)
      IDLE, STOP: begin
        if (accept) begin
          // Word and parity enable are frozen here; later input changes
          // cannot disturb the frame in flight.
          state_d  = START;
          shreg_d  = P_DATA_TXC;
          par_en_d = PAR_EN_TXC;
          cnt_d    = '0;
          tx_d     = 1'b0;
        end else begin
          state_d  = IDLE;
          tx_d     = 1'b1;
        end
      end

      START: begin
        // Leaving the start bit: present data bit 0 and expose bit 1.
        state_d = DATA;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          if (par_en_q) begin
            // Parity is sampled only on this edge; upstream guarantees it
            // is settled for the current word by now.
            state_d = PARITY;
            tx_d    = par_bit_TXC;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end

      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces an idle, high line at once.
  always_ff @(posedge CLK_TXC or posedge RST_TXC) begin
    if (RST_TXC) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
    end
  end

  assign TX_OUT_TXC = tx_q;

  // Busy drops in the stop cycle so a queued word can follow immediately.
  assign busy_TXC = (state_q == START) || (state_q == DATA) || (state_q == PARITY);

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Frame controller and serializer for the UART transmitter. It sits directly downstream of the parity calculator. It accepts a parallel data word with a valid strobe and drives the serial line with start bit, data bits LSB-first, optional parity bit and stop bit. The parity value itself comes from the parity stage via `par_bit_TXC`. One serial bit is sent per clock, so the block is clocked at the baud rate.

## Interface
- `DATA_SIZE`, default 8: data word width; must be ≥ 1. The bit counter is `$clog2(DATA_SIZE)` bits wide, minimum 1.
- `CLK_TXC` input, 1 bit: the single clock, one tick per serial bit.
- `RST_TXC` input, 1 bit: reset, asynchronous and active-high.
- `P_DATA_TXC` input, `DATA_SIZE` bits: parallel word to transmit.
- `Data_valid_TXC` input, 1 bit: request strobe, sampled on each rising edge.
- `PAR_EN_TXC` input, 1 bit: 1 inserts a parity bit; sampled only at acceptance.
- `par_bit_TXC` input, 1 bit: parity bit from the parity stage; sent as-is, with no inversion.
- `TX_OUT_TXC` output, 1 bit: serial line, registered, idles high.
- `busy_TXC` output, 1 bit: 1 means a new request will be ignored; decoded from state.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: at a rising edge where the state is IDLE or STOP and `Data_valid_TXC`=1:
  - latch `P_DATA_TXC` into the shift register;
  - latch `PAR_EN_TXC` into `par_en_q`;
  - clear the bit counter;
  - go to START.
- Requests in any other state are ignored. A change to `P_DATA_TXC` or `PAR_EN_TXC` mid-frame has no effect.
- START goes to DATA after 1 cycle.
- DATA stays for exactly `DATA_SIZE` cycles, sending shift register bit 0 first and shifting right each cycle. The counter runs from 0 to `DATA_SIZE`-1.
- On the last DATA cycle the next state is PARITY if `par_en_q`=1, otherwise STOP.
- PARITY goes to STOP after 1 cycle.
- STOP with no acceptance goes to IDLE.
- STOP with acceptance goes to START, giving back-to-back frames with no idle gap.
- IDLE stays in IDLE without `Data_valid_TXC`.
- `TX_OUT_TXC` is a register loaded at the same edge as the state, with the value for the next state:
  - START: 0;
  - DATA: current data bit;
  - PARITY: `par_bit_TXC` sampled at the DATA→PARITY edge;
  - STOP and IDLE: 1.
- `busy_TXC` is 1 in START, DATA and PARITY, and 0 in IDLE and STOP.
- Reset (async, any time including mid-frame):
  - state IDLE, `TX_OUT_TXC`=1, `busy_TXC`=0;
  - shift register, counter and `par_en_q` cleared to 0;
  - after release, the first edge behaves as in IDLE.

## Timing
- Let E0 be the acceptance edge and Ek the k-th edge after it.
- Start bit: `TX_OUT_TXC`=0 during E0–E1.
- Data bit i: driven during E(1+i)–E(2+i), for i = 0..`DATA_SIZE`-1.
- With parity (`DATA_SIZE`=8):
  - parity bit during E9–E10, value of `par_bit_TXC` at E9;
  - stop bit during E10–E11.
  - Frame length is 11 cycles.
- Without parity: stop bit during E9–E10. Frame length is 10 cycles.
- `busy_TXC` rises immediately after E0 and falls at the start of the stop cycle.
- A request presented in the stop cycle is accepted at that cycle's closing edge, and its start bit follows at once.
- Contract with upstream: `par_bit_TXC` must be stable for the word being sent by the DATA→PARITY edge. It is not sampled at any other time.
- Latency from the acceptance edge to the first line transition is 0 cycles (registered output changes at E0).

## Test plan
- Reset: assert `RST_TXC` with no clock running → `TX_OUT_TXC`=1 and `busy_TXC`=0 immediately. Hold 3 cycles with `Data_valid_TXC`=1 → no frame starts.
- Parity frame: 0xA5, `PAR_EN_TXC`=1, `par_bit_TXC`=0 → line reads 0,1,0,1,0,0,1,0,1,0,1 over E0–E11, then idle 1. `busy_TXC` is high for 10 cycles.
- No-parity frame: 0x3C, `PAR_EN_TXC`=0 → line reads 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then IDLE.
- Back-to-back: 0xFF (parity on, `par_bit_TXC`=1), then 0x00 pulsed during the first frame's stop cycle → 1 stop cycle, then the second start bit immediately, then eight 0s, parity, stop.
- Ignored request: pulse `Data_valid_TXC` with 0x55 during the DATA state of a 0x0F frame → the 0x0F frame completes unchanged, the line returns to 1, no second frame.
- Mid-frame reset: assert `RST_TXC` on the 4th data bit → `TX_OUT_TXC`=1 at once. After release, a new 0x81 frame transmits correctly.
